// File: rtl/key_scan_pkg.sv
// Shared definitions for the key debouncer: FSM encoding, default timing
// constants and the counter width helper.
package key_scan_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_st_e;

    localparam int DEF_DEBOUNCE_CNT = 1_000_000;
    localparam int DEF_LONG_CNT     = 50_000_000;

    // Width of a counter that must hold 0 .. n-1.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// Single-key debouncer: 2-FF synchroniser, debounce FSM and counter, plus the
// optional long-press counter (built only when KEY_LONGPRESS_EN is defined).
module key_debounce_cell
    import key_scan_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
    parameter int LONG_CNT     = DEF_LONG_CNT
) (
    input  logic clk,
    input  logic n_reset,
    input  logic key_n,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int            CW      = cnt_w(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT - 1);

    logic          r_s1, r_s2;
    key_st_e       r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_key_state, r_press, r_release;
    logic          w_press_nxt, w_release_nxt;

    // Synchronisers idle at 1 so a key held through reset is seen as a new press.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= key_n;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_key_state <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            if (w_press_nxt)
                r_key_state <= 1'b1;
            else if (w_release_nxt)
                r_key_state <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_s2) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (r_s2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            HELD: begin
                if (r_s2) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!r_s2) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign key_state   = r_key_state;
    assign key_press   = r_press;
    assign key_release = r_release;

`ifdef KEY_LONGPRESS_EN
    localparam int            LW       = cnt_w(LONG_CNT);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CNT - 1);

    logic [LW-1:0] r_lcnt;
    logic          r_long;
    logic          w_down;

    assign w_down = (r_state == HELD) || (r_state == RELEASE_WAIT);

    // Cleared only by an accepted press, so release bounces cannot re-arm it;
    // saturation then limits key_long to one pulse per press.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_lcnt <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (w_press_nxt) begin
                r_lcnt <= '0;
            end else if (w_down && (r_lcnt != LONG_MAX)) begin
                r_lcnt <= r_lcnt + LW'(1);
                r_long <= (r_lcnt == LONG_MAX - LW'(1));
            end
        end
    end

    assign key_long = r_long;
`else
    logic w_unused_long;
    assign w_unused_long = (LONG_CNT > 0);
    assign key_long      = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_scan.sv
// NUM_KEYS active-low push-button debouncer with press/release pulses.
// Define KEY_LONGPRESS_EN to build the per-key long-press detector.
module key_debounce_scan
    import key_scan_pkg::*;
#(
    parameter int NUM_KEYS     = 4,
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
    parameter int LONG_CNT     = DEF_LONG_CNT
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    logic [NUM_KEYS-1:0] w_state, w_press, w_release, w_long;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce_cell #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT),
            .LONG_CNT     (LONG_CNT)
        ) u_cell (
            .clk         (clk),
            .n_reset     (n_reset),
            .key_n       (key_n[k]),
            .key_state   (w_state[k]),
            .key_press   (w_press[k]),
            .key_release (w_release[k]),
            .key_long    (w_long[k])
        );
    end

    assign key_state   = w_state;
    assign key_press   = w_press;
    assign key_release = w_release;
    assign key_long    = w_long;

endmodule
